pcs_rx_link_seq: RTL and testbench
==================================

# pcs_rx_link_seq

Receive-side link bring-up sequencer for the 4-lane 25G/28G PCS + RS-FEC receive path. It drives lane reset and per-lane polarity, then qualifies the lane status in order: block lock, then alignment-marker lock, then deskew. It declares link-up only when all three hold, and it re-enters bring-up on loss of lock or high BER. It sits between the link configuration straps (polarity/block-lock infer-or-given) and the per-lane lock/deskew logic.

## Interface
- NLANES, 4, number of physical lanes
- LOCK_TIMEOUT, 4096, cycles allowed per lock/deskew phase before timeout
- RETRY_MAX, 8, block-lock timeouts before a full lane reset
- RST_HOLD, 16, cycles lane_rst is held
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- infer_polar  in  1  1: sequencer searches polarity; 0: use given_polar
- given_polar  in  NLANES  forced per-lane polarity inversion
- infer_blocklock  in  1  1: use block_lock inputs; 0: use given_blocklock
- given_blocklock  in  NLANES  forced per-lane block-lock status
- block_lock  in  NLANES  per-lane 64b/66b block lock
- am_lock  in  NLANES  per-lane alignment-marker lock
- deskew_done  in  1  lane deskew complete (level)
- hi_ber  in  1  high bit-error-rate indication
- lane_rst  out  NLANES  per-lane datapath reset, all bits equal
- polar_inv  out  NLANES  per-lane RX polarity inversion
- deskew_start  out  1  one-cycle pulse starting deskew
- link_up  out  1  link usable
- state  out  3  current FSM state encoding
- restart_cnt  out  8  saturating count of entries to LANE_RST after reset

## Operation
- Effective lock: blk = infer_blocklock ? block_lock : given_blocklock.
- Effective polarity: when infer_polar=0, polar_inv = given_polar continuously. No toggling.
- States: LANE_RST(0), BLK_LOCK(1), AM_LOCK(2), DESKEW(3), UP(4).
- One shared timer, 0..LOCK_TIMEOUT-1. It clears on every state entry.
- LANE_RST: lane_rst all-ones for RST_HOLD cycles, then go to BLK_LOCK. tmo_cnt clears.
- BLK_LOCK, all blk bits set: go to AM_LOCK.
- BLK_LOCK timeout:
  - If infer_polar=1, toggle polar_inv[i] for every lane with blk[i]=0.
  - Increment tmo_cnt.
  - If tmo_cnt reaches RETRY_MAX, go to LANE_RST. Otherwise restart the timer and stay.
- AM_LOCK:
  - All am_lock set: pulse deskew_start and go to DESKEW.
  - Timeout: go to LANE_RST.
  - Any blk bit drops: go to BLK_LOCK.
- DESKEW:
  - deskew_done: go to UP.
  - Timeout: go to LANE_RST.
  - Any blk bit drops: go to BLK_LOCK.
  - Any am_lock bit drops: go to AM_LOCK.
- UP:
  - hi_ber, or any blk bit drops: go to BLK_LOCK.
  - Else any am_lock bit drops: go to AM_LOCK.
  - Else deskew_done drops: go to DESKEW, with deskew_start pulsed.
- Priority on simultaneous events: blk loss / hi_ber, then am_lock loss, then deskew loss, then timeout, then the forward transition.
- polar_inv is kept across LANE_RST. A found polarity survives relock.
- restart_cnt increments on every entry to LANE_RST except the reset-forced one, and saturates at 255.

## Timing
- Reset values:
  - state = LANE_RST.
  - lane_rst = all-ones. The hold count starts on the first cycle after rst deasserts.
  - polar_inv = given_polar if infer_polar=0, else 0.
  - deskew_start = 0, link_up = 0, restart_cnt = 0, timer = 0, tmo_cnt = 0.
- All outputs are registered.
- link_up rises on the cycle state becomes UP. It falls on the same cycle state leaves UP.
- lane_rst is high for exactly RST_HOLD cycles per LANE_RST visit.
- Input condition sampled at cycle t: state changes at t+1.
- deskew_start is high for exactly one cycle, coincident with the first DESKEW cycle.
- A timeout fires when the timer equals LOCK_TIMEOUT-1 and no higher-priority event is present.
- A polarity toggle appears on polar_inv on the cycle after the timeout cycle.
- rst asserted mid-operation: everything returns to reset values on the next edge, regardless of state.

## Structure
- Shared package pcs25g_pkg holds:
  - state enum rx_seq_state_e (LANE_RST..UP, 3-bit).
  - Default constants for LOCK_TIMEOUT, RETRY_MAX, RST_HOLD.
- One sub-module, pcs_seq_timer: loadable up-counter with a terminal-count flag. It is reused for both the RST_HOLD and LOCK_TIMEOUT phases.
- Per-lane polarity toggle logic is a generate loop in the top module.

## Test plan
- Clean bring-up: infer_polar=1, all locks asserted 10 cycles after lane_rst falls, deskew_done 5 cycles after deskew_start -> link_up=1, polar_inv=0000, restart_cnt=0.
- Inverted lanes 1 and 3: block_lock[1] and block_lock[3] rise only when polar_inv[1]=polar_inv[3]=1 -> polar_inv=1010 after one timeout (LOCK_TIMEOUT cycles), then link_up.
- Lane 2 never locks: after RETRY_MAX timeouts -> LANE_RST with lane_rst=1111 for 16 cycles, restart_cnt=1, polar_inv[2] toggled 8 times (0).
- In UP, block_lock and am_lock drop in the same cycle -> state BLK_LOCK (not AM_LOCK) next cycle, link_up=0 that cycle.
- Given mode: infer_polar=0, given_polar=0110, infer_blocklock=0, given_blocklock=1111, block_lock=0000 -> polar_inv=0110 from reset, AM_LOCK reached with no timeouts.
- rst asserted while in DESKEW -> next cycle state=LANE_RST, link_up=0, restart_cnt=0, deskew_start=0.

Source files
------------

// File: rtl/pcs25g_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pcs25g_pkg                                                                 |
// | Shared types and default constants for the 25G/28G PCS receive sequencer.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pcs25g_pkg;

    typedef enum logic [2:0] {
        LANE_RST = 3'd0,
        BLK_LOCK = 3'd1,
        AM_LOCK  = 3'd2,
        DESKEW   = 3'd3,
        UP       = 3'd4
    } rx_seq_state_e;

    localparam int unsigned C_NLANES       = 4;
    localparam int unsigned C_LOCK_TIMEOUT = 4096;
    localparam int unsigned C_RETRY_MAX    = 8;
    localparam int unsigned C_RST_HOLD     = 16;

endpackage
`default_nettype wire

// File: rtl/pcs_seq_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pcs_seq_timer                                                              |
// | Loadable up-counter with terminal-count flag; wraps to zero on terminal.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pcs_seq_timer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_tc_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    assign o_tc = (r_cnt == i_tc_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcs_rx_link_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pcs_rx_link_seq                                                            |
// | RX link bring-up sequencer: lane reset, polarity search, lock qualifying.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pcs_rx_link_seq
    import pcs25g_pkg::*;
#(
    parameter int unsigned NLANES       = C_NLANES,
    parameter int unsigned LOCK_TIMEOUT = C_LOCK_TIMEOUT,
    parameter int unsigned RETRY_MAX    = C_RETRY_MAX,
    parameter int unsigned RST_HOLD     = C_RST_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              infer_polar,
    input  logic [NLANES-1:0] given_polar,
    input  logic              infer_blocklock,
    input  logic [NLANES-1:0] given_blocklock,
    input  logic [NLANES-1:0] block_lock,
    input  logic [NLANES-1:0] am_lock,
    input  logic              deskew_done,
    input  logic              hi_ber,
    output logic [NLANES-1:0] lane_rst,
    output logic [NLANES-1:0] polar_inv,
    output logic              deskew_start,
    output logic              link_up,
    output logic [2:0]        state,
    output logic [7:0]        restart_cnt
);

    localparam int unsigned c_TMAX = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
    localparam int unsigned c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
    localparam int unsigned c_RW   = $clog2(RETRY_MAX + 1);

    localparam logic [c_TW-1:0] c_LOCK_TC = c_TW'(LOCK_TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_HOLD_TC = c_TW'(RST_HOLD - 1);
    localparam logic [c_RW-1:0] c_RETRY   = c_RW'(RETRY_MAX);

    rx_seq_state_e     r_state;
    rx_seq_state_e     w_nxt;
    logic [c_RW-1:0]   r_tmo;
    logic [c_RW-1:0]   w_tmo_inc;
    logic [NLANES-1:0] r_polar;
    logic [NLANES-1:0] w_polar_d;
    logic [NLANES-1:0] r_lane_rst;
    logic [NLANES-1:0] w_lane_rst_d;
    logic [NLANES-1:0] w_blk;
    logic [7:0]        r_restart;
    logic              r_dsk_start;
    logic              r_link_up;
    logic              w_dsk_start_d;
    logic              w_link_up_d;
    logic              w_rst_entry;
    logic              w_blk_all;
    logic              w_am_all;
    logic              w_tc;
    logic              w_blk_tmo;
    logic              w_state_chg;
    logic [c_TW-1:0]   w_tc_val;

    assign w_blk       = infer_blocklock ? block_lock : given_blocklock;
    assign w_blk_all   = &w_blk;
    assign w_am_all    = &am_lock;
    assign w_tmo_inc   = r_tmo + 1'b1;
    assign w_blk_tmo   = (r_state == BLK_LOCK) && w_tc;
    assign w_state_chg = (w_nxt != r_state);
    assign w_tc_val    = (r_state == LANE_RST) ? c_HOLD_TC : c_LOCK_TC;

    // One timer serves the reset hold and every lock phase; reloaded on each state entry.
    pcs_seq_timer #(
        .WIDTH      (c_TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_state_chg),
        .i_load_val ({c_TW{1'b0}}),
        .i_tc_val   (w_tc_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LANE_RST;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Loss events outrank timeouts, which outrank forward progress.
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            LANE_RST: begin
                if (w_tc) w_nxt = BLK_LOCK;
            end
            BLK_LOCK: begin
                if (w_tc) begin
                    if (w_tmo_inc == c_RETRY) w_nxt = LANE_RST;
                end else if (w_blk_all) begin
                    w_nxt = AM_LOCK;
                end
            end
            AM_LOCK: begin
                if (!w_blk_all)    w_nxt = BLK_LOCK;
                else if (w_tc)     w_nxt = LANE_RST;
                else if (w_am_all) w_nxt = DESKEW;
            end
            DESKEW: begin
                if (!w_blk_all)       w_nxt = BLK_LOCK;
                else if (!w_am_all)   w_nxt = AM_LOCK;
                else if (w_tc)        w_nxt = LANE_RST;
                else if (deskew_done) w_nxt = UP;
            end
            UP: begin
                if (hi_ber || !w_blk_all) w_nxt = BLK_LOCK;
                else if (!w_am_all)       w_nxt = AM_LOCK;
                else if (!deskew_done)    w_nxt = DESKEW;
            end
            default: w_nxt = LANE_RST;
        endcase
    end

    always_comb begin
        w_lane_rst_d  = {NLANES{w_nxt == LANE_RST}};
        w_dsk_start_d = (w_nxt == DESKEW) && (r_state != DESKEW);
        w_link_up_d   = (w_nxt == UP);
        w_rst_entry   = (w_nxt == LANE_RST) && (r_state != LANE_RST);
    end

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_polar
            assign w_polar_d[gi] = !infer_polar ? given_polar[gi] :
                                   (w_blk_tmo && !w_blk[gi]) ? ~r_polar[gi] : r_polar[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_rst  <= '1;
            r_dsk_start <= 1'b0;
            r_link_up   <= 1'b0;
            r_restart   <= 8'd0;
            r_tmo       <= '0;
            r_polar     <= infer_polar ? '0 : given_polar;
        end else begin
            r_lane_rst  <= w_lane_rst_d;
            r_dsk_start <= w_dsk_start_d;
            r_link_up   <= w_link_up_d;
            r_polar     <= w_polar_d;
            if (w_rst_entry && (r_restart != 8'hFF)) begin
                r_restart <= r_restart + 8'd1;
            end
            if (r_state == LANE_RST) begin
                r_tmo <= '0;
            end else if (w_blk_tmo) begin
                r_tmo <= w_tmo_inc;
            end
        end
    end

    assign lane_rst     = r_lane_rst;
    assign polar_inv    = r_polar;
    assign deskew_start = r_dsk_start;
    assign link_up      = r_link_up;
    assign state        = r_state;
    assign restart_cnt  = r_restart;

endmodule
`default_nettype wire

// File: tb/tb_pcs_rx_link_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pcs_rx_link_seq                                                         |
// | Directed/randomized bench with a lane environment and rule-level model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pcs_rx_link_seq;
    import pcs25g_pkg::*;

    localparam int NL = 4;
    localparam int LT = 64;
    localparam int RM = 8;
    localparam int RH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          infer_polar, infer_blocklock, deskew_done, hi_ber;
    logic [NL-1:0] given_polar, given_blocklock, block_lock, am_lock;
    logic [NL-1:0] lane_rst, polar_inv;
    logic          deskew_start, link_up;
    logic [2:0]    state;
    logic [7:0]    restart_cnt;

    int            n_checks = 0;
    int            n_err    = 0;

    // Lane environment: a lane locks when its polarity matches the wire and it is not dead.
    logic          env_auto, env_am;
    logic [NL-1:0] need_inv, dead;

    always #5 clk = ~clk;

    pcs_rx_link_seq #(
        .NLANES          (NL),
        .LOCK_TIMEOUT    (LT),
        .RETRY_MAX       (RM),
        .RST_HOLD        (RH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .infer_polar     (infer_polar),
        .given_polar     (given_polar),
        .infer_blocklock (infer_blocklock),
        .given_blocklock (given_blocklock),
        .block_lock      (block_lock),
        .am_lock         (am_lock),
        .deskew_done     (deskew_done),
        .hi_ber          (hi_ber),
        .lane_rst        (lane_rst),
        .polar_inv       (polar_inv),
        .deskew_start    (deskew_start),
        .link_up         (link_up),
        .state           (state),
        .restart_cnt     (restart_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic env_update();
        if (env_auto) begin
            for (int i = 0; i < NL; i++)
                block_lock[i] = ~dead[i] & (polar_inv[i] == need_inv[i]);
            am_lock = env_am ? 4'hF : 4'h0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        env_update();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_state", state, LANE_RST);
        chk("rst_lane_rst", lane_rst, 4'hF);
        chk("rst_link_up", link_up, 1'b0);
        chk("rst_dsk_start", deskew_start, 1'b0);
        chk("rst_restart", restart_cnt, 8'd0);
        chk("rst_polar", polar_inv, infer_polar ? 4'h0 : given_polar);
        rst = 1'b0;
    endtask

    task automatic wait_hold(input string tag);
        int n = 0;
        while (lane_rst == 4'hF && n < 200) begin
            n++;
            tick();
        end
        chk(tag, n, RH);
        chk({tag, "_state"}, state, BLK_LOCK);
    endtask

    task automatic count_until(input logic [2:0] tgt, input int lim, output int n);
        n = 0;
        while (state !== tgt && n < lim) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        int           dly;
        logic [3:0]   ev;
        logic [2:0]   exp_st;
        int           lane;
        int           exp_rec;

        rst = 1'b1; infer_polar = 1'b1; infer_blocklock = 1'b1;
        given_polar = '0; given_blocklock = '0; block_lock = '0; am_lock = '0;
        deskew_done = 1'b0; hi_ber = 1'b0;
        env_auto = 1'b0; env_am = 1'b0; need_inv = '0; dead = '0;

        // Clean bring-up
        do_reset();
        wait_hold("s1_hold");
        repeat (10) tick();
        env_auto = 1'b1; env_am = 1'b1; env_update();
        count_until(AM_LOCK, 50, n);
        chk("s1_to_am", n, 1);
        tick();
        chk("s1_dsk_state", state, DESKEW);
        chk("s1_dsk_start", deskew_start, 1'b1);
        tick();
        chk("s1_dsk_pulse", deskew_start, 1'b0);
        repeat (3) tick();
        deskew_done = 1'b1;
        tick();
        chk("s1_up_state", state, UP);
        chk("s1_link_up", link_up, 1'b1);
        chk("s1_polar", polar_inv, 4'h0);
        chk("s1_restart", restart_cnt, 8'd0);

        // Events while UP, resolved by priority
        for (int k = 0; k < 10; k++) begin
            ev = 4'($urandom_range(1, 15));
            if (k == 0) ev = 4'b0011;
            lane = $urandom_range(0, NL - 1);
            env_auto = 1'b0;
            block_lock  = ev[0] ? ~(4'b0001 << lane) : 4'hF;
            am_lock     = ev[1] ? ~(4'b0001 << lane) : 4'hF;
            deskew_done = ~ev[2];
            hi_ber      = ev[3];
            exp_st  = (ev[0] || ev[3]) ? BLK_LOCK : ev[1] ? AM_LOCK : DESKEW;
            exp_rec = (exp_st == BLK_LOCK) ? 3 : (exp_st == AM_LOCK) ? 2 : 1;
            tick();
            chk("up_ev_state", state, exp_st);
            chk("up_ev_link", link_up, 1'b0);
            chk("up_ev_dsk_start", deskew_start, exp_st == DESKEW);
            hi_ber = 1'b0; deskew_done = 1'b1;
            env_auto = 1'b1; env_update();
            count_until(UP, 20, n);
            chk("up_recover", n, exp_rec);
        end

        // Polarity search: fixed lanes 1/3 first, then random lane patterns
        for (int k = 0; k < 4; k++) begin
            env_auto = 1'b0; block_lock = '0; am_lock = '0; deskew_done = 1'b0;
            do_reset();
            wait_hold("s2_hold");
            need_inv = (k == 0) ? 4'b1010 : 4'($urandom_range(0, 15));
            dly = (k == 0) ? 0 : $urandom_range(0, 40);
            repeat (dly) tick();
            env_auto = 1'b1; env_am = 1'b1; env_update();
            count_until(AM_LOCK, 300, n);
            chk("s2_to_am", n + dly, (need_inv != 0) ? LT + 1 : dly + 1);
            chk("s2_polar", polar_inv, need_inv);
            tick();
            chk("s2_dsk_start", deskew_start, 1'b1);
            deskew_done = 1'b1;
            tick();
            chk("s2_link_up", link_up, 1'b1);
            chk("s2_restart", restart_cnt, 8'd0);
        end

        // Dead lane 2: retries exhaust, lane reset, then rst while in DESKEW
        need_inv = '0; dead = 4'b0100; env_auto = 1'b1; env_am = 1'b1; deskew_done = 1'b0;
        do_reset();
        wait_hold("s3_hold");
        n = 0;
        while (state == BLK_LOCK && n < RM * LT + 50) begin
            if (n == LT) chk("s3_first_toggle", polar_inv, 4'b0100);
            tick();
            n++;
        end
        chk("s3_retry_time", n, RM * LT);
        chk("s3_state", state, LANE_RST);
        chk("s3_lane_rst", lane_rst, 4'hF);
        chk("s3_restart", restart_cnt, 8'd1);
        chk("s3_polar", polar_inv, 4'h0);
        wait_hold("s3_hold2");
        dead = '0; env_update();
        count_until(DESKEW, 10, n);
        chk("s3_to_dsk", n, 2);
        tick();
        chk("s3_in_dsk", state, DESKEW);
        rst = 1'b1;
        tick();
        chk("s3_rst_state", state, LANE_RST);
        chk("s3_rst_link", link_up, 1'b0);
        chk("s3_rst_restart", restart_cnt, 8'd0);
        chk("s3_rst_dsk", deskew_start, 1'b0);
        rst = 1'b0;

        // Given mode: straps override polarity and block lock
        env_auto = 1'b0;
        infer_polar = 1'b0; given_polar = 4'b0110;
        infer_blocklock = 1'b0; given_blocklock = 4'hF;
        block_lock = '0; am_lock = '0; deskew_done = 1'b0;
        do_reset();
        wait_hold("s5_hold");
        chk("s5_polar", polar_inv, 4'b0110);
        count_until(AM_LOCK, 10, n);
        chk("s5_to_am", n, 1);
        count_until(LANE_RST, LT + 10, n);
        chk("s5_am_timeout", n, LT);
        chk("s5_restart", restart_cnt, 8'd1);
        chk("s5_polar_kept", polar_inv, 4'b0110);
        wait_hold("s5_hold2");
        tick();
        chk("s5_am_again", state, AM_LOCK);
        given_blocklock = 4'b1011;
        tick();
        chk("s5_blk_drop", state, BLK_LOCK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
